// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
//
// Posted-store FIFO sitting between the core's memory-stage store port and a
// slower external data memory. The core may push one store per cycle; entries
// drain in program order over a valid/ready handshake. The core is stalled only
// when the buffer is full.
//
// Parameters
//    ADDR_W  store address width
//    DATA_W  store data width
//    DEPTH   number of entries (power of two, >= 2)
//
// Ports
//    clk            clock, all state updates on the rising edge
//    rst            asynchronous active-low reset
//    cpu_mem_write  store request from the core
//    cpu_data_adr   store address
//    cpu_write_data store data
//    cpu_stall      store not accepted this cycle; core holds its request
//    mem_valid      head entry presented to external memory
//    mem_adr        head entry address (0 when empty)
//    mem_wdata      head entry data (0 when empty)
//    mem_ready      external memory accepts the head this cycle
//    count          occupied entries, 0..DEPTH
//    empty          count == 0
//
// Optional feature
//    WB_COALESCE_EN: a store whose address matches the most recently pushed
//    entry overwrites that entry's data in place, provided that entry is not
//    the head currently being presented. Such a store is accepted even when
//    the buffer is full.
// -----------------------------------------------------------------------------
module store_write_buffer #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 22,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_mem_write,
   input  logic [ADDR_W-1:0]        cpu_data_adr,
   input  logic [DATA_W-1:0]        cpu_write_data,
   output logic                     cpu_stall,
   output logic                     mem_valid,
   output logic [ADDR_W-1:0]        mem_adr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Entry storage; deliberately not reset.
   logic [ADDR_W-1:0] adr_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;

   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             full;
   logic             push;
   logic             pop;
   logic             coalesce;
   logic [IDX_W-1:0] coalesce_idx;

   assign wr_idx = wr_ptr_reg[IDX_W-1:0];
   assign rd_idx = rd_ptr_reg[IDX_W-1:0];

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) && (wr_idx == rd_idx);
   assign count = wr_ptr_reg - rd_ptr_reg;

`ifdef WB_COALESCE_EN
   // The most recently pushed entry sits just behind wr_ptr. It is only safe to
   // merge into it when it is not the head, i.e. at least two entries are held.
   assign coalesce_idx = wr_idx - IDX_W'(1);
   assign coalesce     = cpu_mem_write
                         && (count >= PTR_W'(2))
                         && (adr_mem[coalesce_idx] == cpu_data_adr);
`else
   assign coalesce_idx = '0;
   assign coalesce     = 1'b0;
`endif

   // A full buffer refuses the push even if the head pops this same cycle.
   assign push      = cpu_mem_write && !full && !coalesce;
   assign cpu_stall = cpu_mem_write && full && !coalesce;
   assign pop       = mem_valid && mem_ready;

   assign mem_valid = !empty;
   assign mem_adr   = empty ? '0 : adr_mem[rd_idx];
   assign mem_wdata = empty ? '0 : data_mem[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         adr_mem[wr_idx]  <= cpu_data_adr;
         data_mem[wr_idx] <= cpu_write_data;
      end else if (coalesce) begin
         data_mem[coalesce_idx] <= cpu_write_data;
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

   localparam int ADDR_W = 22;
   localparam int DATA_W = 22;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              rst;
   logic              cpu_mem_write;
   logic [ADDR_W-1:0] cpu_data_adr;
   logic [DATA_W-1:0] cpu_write_data;
   logic              cpu_stall;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [2:0]        count;
   logic              empty;

   int tests;
   int fails;

   store_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .cpu_mem_write(cpu_mem_write),
      .cpu_data_adr(cpu_data_adr),
      .cpu_write_data(cpu_write_data),
      .cpu_stall(cpu_stall),
      .mem_valid(mem_valid),
      .mem_adr(mem_adr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .count(count),
      .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic rdy);
      cpu_mem_write  = wr;
      cpu_data_adr   = a;
      cpu_write_data = d;
      mem_ready      = rdy;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", mem_valid); end
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b want 1", empty); end
      tick();
      rst = 1'b1;
      // fill three entries, then reset asynchronously mid-cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ADDR_W'(22'h70 + i), DATA_W'(22'h700 + i), 1'b0);
         tick();
      end
      drive(1'b1, 22'h7F, 22'h7FF, 1'b0);
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL pre_reset_count got %0d want 3", count); end
      #2 rst = 1'b0;
      #1;
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL midrun_reset_valid got %0b want 0", mem_valid); end
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL midrun_reset_count got %0d want 0", count); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrun_reset_empty got %0b want 1", empty); end
      tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL midrun_reset_stall got %0b want 0", cpu_stall); end
      tests++; if (mem_adr !== 22'h0) begin fails++; $display("FAIL midrun_reset_adr got %h want 0", mem_adr); end
      tick();
      tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_hold_count got %0d want 0", count); end
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b1;
      #1;
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      drive(1'b1, 22'h000010, 22'h0ABCDE, 1'b1);
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %0b want 0", mem_valid); end
      tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL single_stall got %0b want 0", cpu_stall); end
      tick();
      drive(1'b0, '0, '0, 1'b1);
      tests++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", mem_valid); end
      tests++; if (mem_adr !== 22'h000010) begin fails++; $display("FAIL single_adr got %h want 000010", mem_adr); end
      tests++; if (mem_wdata !== 22'h0ABCDE) begin fails++; $display("FAIL single_data got %h want 0abcde", mem_wdata); end
      tick();
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty_after got %0b want 1", empty); end
      tests++; if (mem_adr !== 22'h0) begin fails++; $display("FAIL single_adr_zero got %h want 0", mem_adr); end
      $display("[TB] test_single done");
   endtask

   task automatic test_full_stall();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, ADDR_W'(i), DATA_W'(22'h100 + i), 1'b0);
         tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL fill_stall_%0d got %0b want 0", i, cpu_stall); end
         tick();
      end
      drive(1'b1, 22'h5, 22'h105, 1'b0);
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", count); end
      tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL full_stall got %0b want 1", cpu_stall); end
      tick();
      tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_hold_count got %0d want 4", count); end
      // raise ready with the 5th store still held
      drive(1'b1, 22'h5, 22'h105, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         tests++; if (mem_valid !== 1'b1 || mem_adr !== ADDR_W'(i) || mem_wdata !== DATA_W'(22'h100 + i)) begin
            fails++; $display("FAIL drain_%0d got v=%0b adr=%h data=%h want adr=%h", i, mem_valid, mem_adr, mem_wdata, i);
         end
         if (i == 1) begin
            tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL drain_stall1 got %0b want 1", cpu_stall); end
         end
         if (i == 2) begin
            tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL drain_stall2 got %0b want 0", cpu_stall); end
         end
         tick();
         if (i == 2) drive(1'b0, '0, '0, 1'b1);
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %0b want 1", empty); end
      $display("[TB] test_full_stall done");
   endtask

   task automatic test_push_pop_same();
      drive(1'b1, 22'h41, 22'h141, 1'b0); tick();
      drive(1'b1, 22'h42, 22'h142, 1'b0); tick();
      drive(1'b1, 22'h43, 22'h143, 1'b1);
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count_before got %0d want 2", count); end
      tests++; if (mem_adr !== 22'h41) begin fails++; $display("FAIL pp_oldest got %h want 41", mem_adr); end
      tick();
      drive(1'b0, '0, '0, 1'b1);
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL pp_count_after got %0d want 2", count); end
      tests++; if (mem_adr !== 22'h42) begin fails++; $display("FAIL pp_head2 got %h want 42", mem_adr); end
      tick();
      tests++; if (mem_adr !== 22'h43 || mem_wdata !== 22'h143) begin fails++; $display("FAIL pp_head3 got %h/%h want 43/143", mem_adr, mem_wdata); end
      tick();
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pp_empty got %0b want 1", empty); end
      $display("[TB] test_push_pop_same done");
   endtask

   task automatic test_full_push_pop();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, ADDR_W'(22'h50 + i), DATA_W'(22'h150 + i), 1'b0);
         tick();
      end
      drive(1'b1, 22'h55, 22'h155, 1'b1);
      tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL fpp_stall got %0b want 1", cpu_stall); end
      tick();
      drive(1'b0, '0, '0, 1'b1);
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL fpp_count got %0d want 3", count); end
      for (int i = 2; i <= 4; i++) begin
         tests++; if (mem_adr !== ADDR_W'(22'h50 + i)) begin fails++; $display("FAIL fpp_drain_%0d got %h want %h", i, mem_adr, 22'h50 + i); end
         tick();
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fpp_empty got %0b want 1", empty); end
      $display("[TB] test_full_push_pop done");
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W+DATA_W-1:0] q[$];
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic rdy, wr, exp_full, popped, pushed;
      int next_k = 0;
      int cyc = 0;
      while (next_k < 12 || q.size() > 0) begin
         if (cyc >= 200) begin
            tests++; fails++; $display("FAIL b2b_timeout got cycles=%0d want <200", cyc);
            break;
         end
         rdy = (cyc % 3) != 0;
         wr  = next_k < 12;
         a   = ADDR_W'(22'h60 + next_k);
         d   = DATA_W'(22'h3000 + next_k);
         drive(wr, a, d, rdy);
         exp_full = (q.size() == DEPTH);
         tests++; if (cpu_stall !== (wr && exp_full)) begin fails++; $display("FAIL b2b_stall_c%0d got %0b want %0b", cyc, cpu_stall, wr && exp_full); end
         if (q.size() > 0) begin
            tests++; if (mem_valid !== 1'b1 || {mem_adr, mem_wdata} !== q[0]) begin
               fails++; $display("FAIL b2b_head_c%0d got v=%0b %h/%h want %h", cyc, mem_valid, mem_adr, mem_wdata, q[0]);
            end
         end else begin
            tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_c%0d got %0b want 0", cyc, mem_valid); end
         end
         popped = (q.size() > 0) && rdy;
         pushed = wr && !exp_full;
         tick();
         if (popped) void'(q.pop_front());
         if (pushed) begin
            q.push_back({a, d});
            next_k++;
         end
         tests++; if (count !== 3'(q.size())) begin fails++; $display("FAIL b2b_count_c%0d got %0d want %0d", cyc, count, q.size()); end
         cyc++;
      end
      drive(1'b0, '0, '0, 1'b0);
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %0b want 1", empty); end
      $display("[TB] test_back_to_back done in %0d cycles", cyc);
   endtask

   task automatic test_coalesce();
      logic [ADDR_W+DATA_W-1:0] exp_list[$];
      drive(1'b1, 22'h30, 22'h1, 1'b0); tick();
      drive(1'b1, 22'h20, 22'h1, 1'b0); tick();
      drive(1'b1, 22'h20, 22'h2, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b0);
`ifdef WB_COALESCE_EN
      exp_list = '{{22'h30, 22'h1}, {22'h20, 22'h2}};
`else
      exp_list = '{{22'h30, 22'h1}, {22'h20, 22'h1}, {22'h20, 22'h2}};
`endif
      tests++; if (count !== 3'(exp_list.size())) begin fails++; $display("FAIL coal_count got %0d want %0d", count, exp_list.size()); end
      drive(1'b0, '0, '0, 1'b1);
      foreach (exp_list[i]) begin
         tests++; if (mem_valid !== 1'b1 || {mem_adr, mem_wdata} !== exp_list[i]) begin
            fails++; $display("FAIL coal_drain_%0d got v=%0b %h/%h want %h", i, mem_valid, mem_adr, mem_wdata, exp_list[i]);
         end
         tick();
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL coal_empty got %0b want 1", empty); end
      drive(1'b0, '0, '0, 1'b0);
      $display("[TB] test_coalesce done");
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      cpu_mem_write = 1'b0;
      cpu_data_adr = '0;
      cpu_write_data = '0;
      mem_ready = 1'b0;
      test_reset();
      test_single();
      test_full_stall();
      test_push_pop_same();
      test_full_push_pop();
      test_back_to_back();
      test_coalesce();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
